// File: rtl/multicycle_control_pkg.sv
// ============================================================================
// Module   : multicycle_control_pkg
// Summary  : Shared types and constants for the multicycle control FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  // Opcodes are decoded on a fixed 6-bit field regardless of the OP port width.
  localparam int c_opc_w = 6;

  localparam logic [c_opc_w-1:0] OP_ADD = 6'd1;
  localparam logic [c_opc_w-1:0] OP_SW  = 6'd2;
  localparam logic [c_opc_w-1:0] OP_SUB = 6'd3;
  localparam logic [c_opc_w-1:0] OP_LW  = 6'd4;
  localparam logic [c_opc_w-1:0] OP_AND = 6'd5;
  localparam logic [c_opc_w-1:0] OP_OR  = 6'd7;

  localparam logic [1:0] ALU_AND = 2'd0;
  localparam logic [1:0] ALU_OR  = 2'd1;
  localparam logic [1:0] ALU_ADD = 2'd2;
  localparam logic [1:0] ALU_SUB = 2'd3;

  typedef struct packed {
    logic       legal;
    logic       rtype;
    logic       lw;
    logic       sw;
    logic [1:0] aluop;
  } dec_t;

  function automatic logic is_mem(input dec_t d);
    return d.lw | d.sw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_op_decode.sv
// ============================================================================
// Module   : mc_op_decode
// Summary  : Maps a 6-bit opcode to its static datapath controls and legality.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_op_decode
  import multicycle_control_pkg::*;
(
  input  logic [c_opc_w-1:0] i_opc,
  output dec_t               o_dec
);

  always_comb begin
    o_dec       = '0;
    o_dec.legal = 1'b1;
    o_dec.aluop = ALU_ADD;
    case (i_opc)
      OP_ADD: begin
        o_dec.rtype = 1'b1;
        o_dec.aluop = ALU_ADD;
      end
      OP_SUB: begin
        o_dec.rtype = 1'b1;
        o_dec.aluop = ALU_SUB;
      end
      OP_AND: begin
        o_dec.rtype = 1'b1;
        o_dec.aluop = ALU_AND;
      end
      OP_OR: begin
        o_dec.rtype = 1'b1;
        o_dec.aluop = ALU_OR;
      end
      OP_LW:   o_dec.lw = 1'b1;
      OP_SW:   o_dec.sw = 1'b1;
      default: o_dec.legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Summary  : Six-state multicycle CPU control FSM with registered outputs.
//            Define MC_RETIRE_CNT_EN to add the retired-instruction counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  op,
  input  logic            stall,
  input  logic            mem_ready,
  output logic            irwrite,
  output logic            pcwrite,
  output logic            regdst,
  output logic            alusrc,
  output logic            memread,
  output logic            memwrite,
  output logic            memtoreg,
  output logic            regwrite,
  output logic [1:0]      aluop,
  output logic [2:0]      state,
  output logic            illegal
`ifdef MC_RETIRE_CNT_EN
  ,
  output logic [CNTW-1:0] retired
`endif
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_opc_w-1:0] r_opc;
  logic [c_opc_w-1:0] w_op6;
  logic [c_opc_w-1:0] w_opc_nxt;
  dec_t               w_dec;

  logic       r_irwrite, r_pcwrite, r_regdst, r_alusrc, r_memread;
  logic       r_memwrite, r_memtoreg, r_regwrite, r_illegal;
  logic [1:0] r_aluop;

  logic       w_irwrite, w_pcwrite, w_regdst, w_alusrc, w_memread;
  logic       w_memwrite, w_memtoreg, w_regwrite, w_illegal;
  logic [1:0] w_aluop;

  if (OPW >= c_opc_w) begin : g_op_trunc
    assign w_op6 = op[c_opc_w-1:0];
  end else begin : g_op_zext
    assign w_op6 = {{(c_opc_w-OPW){1'b0}}, op};
  end

  // Outside DECODE the decoder sees the held opcode, so one instance serves
  // both the legality check and the per-instruction controls.
  assign w_opc_nxt = (r_state == S_DECODE) ? w_op6 : r_opc;

  mc_op_decode u_op_decode (
    .i_opc (w_opc_nxt),
    .o_dec (w_dec)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = S_FETCH;
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = w_dec.legal ? S_EXEC : S_FETCH;
      S_EXEC:   w_state_nxt = is_mem(w_dec) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ready) w_state_nxt = w_dec.lw ? S_WB : S_FETCH;
      end
      S_WB:     w_state_nxt = S_FETCH;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs for the state about to be entered, so the registers present
  // Moore values aligned with the state register.
  always_comb begin
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_alusrc   = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    w_aluop    = ALU_AND;
    case (w_state_nxt)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        w_illegal = (r_state == S_DECODE);
      end
      S_EXEC, S_MEM, S_WB: begin
        w_aluop  = w_dec.aluop;
        w_alusrc = is_mem(w_dec);
        w_regdst = w_dec.rtype;
        if (w_state_nxt == S_MEM) begin
          w_memread  = w_dec.lw;
          w_memwrite = w_dec.sw;
        end
        if (w_state_nxt == S_WB) begin
          w_regwrite = 1'b1;
          w_memtoreg = w_dec.lw;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_opc      <= '0;
      r_irwrite  <= 1'b0;
      r_pcwrite  <= 1'b0;
      r_regdst   <= 1'b0;
      r_alusrc   <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_regwrite <= 1'b0;
      r_illegal  <= 1'b0;
      r_aluop    <= ALU_AND;
    end else if (!stall) begin
      r_state    <= w_state_nxt;
      r_opc      <= w_opc_nxt;
      r_irwrite  <= w_irwrite;
      r_pcwrite  <= w_pcwrite;
      r_regdst   <= w_regdst;
      r_alusrc   <= w_alusrc;
      r_memread  <= w_memread;
      r_memwrite <= w_memwrite;
      r_memtoreg <= w_memtoreg;
      r_regwrite <= w_regwrite;
      r_illegal  <= w_illegal;
      r_aluop    <= w_aluop;
    end
  end

  // Strobes stay registered through a stall but are masked, so they fire
  // exactly once when the stall releases.
  assign irwrite  = r_irwrite  & ~stall;
  assign pcwrite  = r_pcwrite  & ~stall;
  assign regwrite = r_regwrite & ~stall;
  assign illegal  = r_illegal  & ~stall;
  assign regdst   = r_regdst;
  assign alusrc   = r_alusrc;
  assign memread  = r_memread;
  assign memwrite = r_memwrite;
  assign memtoreg = r_memtoreg;
  assign aluop    = r_aluop;
  assign state    = r_state;

`ifdef MC_RETIRE_CNT_EN
  logic            w_retire;
  logic [CNTW-1:0] r_retired;

  assign w_retire = ~stall & ((r_state == S_WB) |
                              ((r_state == S_MEM) & mem_ready & w_dec.sw));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + 1'b1;
    end
  end

  assign retired = r_retired;
`else
  if (CNTW < 1) begin : g_cntw_unused
  end
`endif

endmodule

`default_nettype wire
